// File: rtl/spi_slave_param_if.sv
// Word-level handshake between the SPI slave and its host logic:
// received words out, words to transmit in, FIFO status back.
interface spi_slave_param_if #(
  parameter int WORD_WIDTH = 8
);
  logic                  o_RX_DV;
  logic [WORD_WIDTH-1:0] o_RX_Word;
  logic                  i_TX_DV;
  logic [WORD_WIDTH-1:0] i_TX_Word;
  logic                  o_TX_Ready;
  logic                  o_TX_Underrun;

  modport slave (
    output o_RX_DV, o_RX_Word, o_TX_Ready, o_TX_Underrun,
    input  i_TX_DV, i_TX_Word
  );

  modport master (
    input  o_RX_DV, o_RX_Word, o_TX_Ready, o_TX_Underrun,
    output i_TX_DV, i_TX_Word
  );
endinterface

// File: rtl/spi_slave_param.sv
// Oversampled SPI slave (modes 0-3, 4-32 bit words, MSb/LSb first) with a TX FIFO.
// Define SPI_SLAVE_PARAM_FRAME_ERR_EN to add the o_Frame_Err pulse output.
module spi_slave_param #(
  parameter int SPI_MODE   = 0,
  parameter int WORD_WIDTH = 8,
  parameter int LSB_FIRST  = 0,
  parameter int TX_DEPTH   = 4
) (
  input  logic             i_Clk,
  input  logic             i_Rst_L,
  spi_slave_param_if.slave bus,
  input  logic             i_SPI_Clk,
  input  logic             i_SPI_MOSI,
  input  logic             i_SPI_CS_n,
  output logic             o_SPI_MISO,
  output logic             o_SPI_MISO_En,
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
  output logic             o_Frame_Err,
`endif
  output logic             o_Busy
);
  localparam bit CPOL  = ((SPI_MODE >> 1) & 1) != 0;
  localparam bit CPHA  = (SPI_MODE & 1) != 0;
  localparam bit LSB   = LSB_FIRST != 0;
  localparam int CNT_W = $clog2(WORD_WIDTH);
  localparam int PTR_W = $clog2(TX_DEPTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_WIDTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(TX_DEPTH);

  typedef enum logic [1:0] {IDLE, ARMED, SHIFT} state_t;

  function automatic logic [WORD_WIDTH-1:0] shift_in(input logic [WORD_WIDTH-1:0] sr,
                                                      input logic b);
    if (LSB) return {b, sr[WORD_WIDTH-1:1]};
    return {sr[WORD_WIDTH-2:0], b};
  endfunction

  function automatic logic [WORD_WIDTH-1:0] shift_out(input logic [WORD_WIDTH-1:0] sr);
    if (LSB) return {1'b0, sr[WORD_WIDTH-1:1]};
    return {sr[WORD_WIDTH-2:0], 1'b0};
  endfunction

  function automatic logic head_bit(input logic [WORD_WIDTH-1:0] sr);
    return LSB ? sr[0] : sr[WORD_WIDTH-1];
  endfunction

  state_t                state;
  logic                  sck_p0, sck_p1, sck_p2;
  logic                  mosi_p0, mosi_p1, mosi_p2;
  logic                  cs_p0, cs_p1, cs_p2;
  logic                  sync_ok_p0, sync_ok_p1;
  logic [CNT_W-1:0]      rx_cnt, tx_cnt;
  logic [WORD_WIDTH-1:0] rx_sr, tx_sr, rx_word;
  logic                  rx_dv, underrun, busy;
  logic                  first_word, commit_pend, peek_empty;
  logic [WORD_WIDTH-1:0] fifo_mem [TX_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [PTR_W:0]        count;
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
  logic                  frame_err;
`endif

  logic sck_rise, sck_fall, sample_edge, shift_edge, cs_fall, cs_rise;
  logic full, empty, push, pop, under, entry, commit, word_end_shift, hold_shift;
  logic [WORD_WIDTH-1:0] rx_next, fifo_head;

  always_comb begin
    sck_rise       = sck_p1 & ~sck_p2;
    sck_fall       = ~sck_p1 & sck_p2;
    // leading edge is the one leaving the idle level CPOL
    sample_edge    = (CPHA ^ CPOL) ? sck_fall : sck_rise;
    shift_edge     = (CPHA ^ CPOL) ? sck_rise : sck_fall;
    cs_fall        = ~cs_p1 & cs_p2;
    cs_rise        = cs_p1 & ~cs_p2;
    full           = (count == FULL_CNT);
    empty          = (count == '0);
    push           = bus.i_TX_DV & ~full;
    fifo_head      = empty ? '0 : fifo_mem[rd_ptr];
    entry          = (state == ARMED) & cs_fall;
    // a word peeked at the word boundary is only consumed once its first bit is clocked
    commit         = (state == SHIFT) & ~cs_rise & sample_edge & commit_pend;
    pop            = (entry & ~empty) | (commit & ~peek_empty);
    under          = (entry & empty) | (commit & peek_empty);
    word_end_shift = CPHA ? ((tx_cnt == '0) & ~first_word) : (tx_cnt == LAST_BIT);
    hold_shift     = CPHA & (tx_cnt == '0) & first_word;
    rx_next        = shift_in(rx_sr, mosi_p2);
  end

  always_ff @(posedge i_Clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.i_TX_Word;
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      state       <= IDLE;
      {sck_p0, sck_p1, sck_p2}    <= '0;
      {mosi_p0, mosi_p1, mosi_p2} <= '0;
      {cs_p0, cs_p1, cs_p2}       <= '0;
      sync_ok_p0  <= 1'b0;
      sync_ok_p1  <= 1'b0;
      rx_cnt      <= '0;
      tx_cnt      <= '0;
      rx_sr       <= '0;
      tx_sr       <= '0;
      rx_word     <= '0;
      rx_dv       <= 1'b0;
      underrun    <= 1'b0;
      busy        <= 1'b0;
      first_word  <= 1'b0;
      commit_pend <= 1'b0;
      peek_empty  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
      frame_err   <= 1'b0;
`endif
    end else begin
      // synchronizer stages p0/p1, history p2
      {sck_p0, sck_p1, sck_p2}    <= {i_SPI_Clk, sck_p0, sck_p1};
      {mosi_p0, mosi_p1, mosi_p2} <= {i_SPI_MOSI, mosi_p0, mosi_p1};
      {cs_p0, cs_p1, cs_p2}       <= {i_SPI_CS_n, cs_p0, cs_p1};
      sync_ok_p0 <= 1'b1;
      sync_ok_p1 <= sync_ok_p0;
      busy       <= sync_ok_p1 & ~cs_p1;
      rx_dv      <= 1'b0;
      underrun   <= under;
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
      frame_err  <= 1'b0;
`endif
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + (PTR_W + 1)'(push) - (PTR_W + 1)'(pop);

      case (state)
        IDLE: if (cs_p1) state <= ARMED;
        ARMED: if (cs_fall) begin
          state       <= SHIFT;
          tx_sr       <= fifo_head;
          first_word  <= 1'b1;
          commit_pend <= 1'b0;
          rx_cnt      <= '0;
          tx_cnt      <= '0;
          rx_sr       <= '0;
        end
        SHIFT: begin
          if (cs_rise) begin
            state       <= ARMED;
            rx_cnt      <= '0;
            tx_cnt      <= '0;
            rx_sr       <= '0;
            commit_pend <= 1'b0;
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
            frame_err   <= (rx_cnt != '0);
`endif
          end else begin
            if (sample_edge) begin
              rx_sr       <= rx_next;
              rx_cnt      <= (rx_cnt == LAST_BIT) ? '0 : rx_cnt + 1'b1;
              commit_pend <= 1'b0;
              if (rx_cnt == LAST_BIT) begin
                rx_word <= rx_next;
                rx_dv   <= 1'b1;
              end
            end
            if (shift_edge) begin
              tx_cnt     <= (tx_cnt == LAST_BIT) ? '0 : tx_cnt + 1'b1;
              first_word <= 1'b0;
              if (word_end_shift) begin
                tx_sr       <= fifo_head;
                commit_pend <= 1'b1;
                peek_empty  <= empty;
              end else if (!hold_shift) begin
                tx_sr <= shift_out(tx_sr);
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.o_RX_DV       = rx_dv;
  assign bus.o_RX_Word     = rx_word;
  assign bus.o_TX_Ready    = ~full;
  assign bus.o_TX_Underrun = underrun;
  assign o_SPI_MISO        = (state == SHIFT) & head_bit(tx_sr);
  assign o_SPI_MISO_En     = (state == SHIFT);
  assign o_Busy            = busy;
`ifdef SPI_SLAVE_PARAM_FRAME_ERR_EN
  assign o_Frame_Err       = frame_err;
`endif
endmodule
